// File: rtl/framebuf_pingpong.sv
// ---------------------------------------------------------------------------
// framebuf_pingpong
//
// Double-buffered frame store for the voxel LED display pipeline. Two banks
// of 2**ADDR_W x DATA_W words: the host side writes and reads the back bank,
// and the scan side streams the front bank out with valid/ready handshaking.
// A bank swap requested by the host waits for a frame boundary, so the LED
// driver never sees a half-updated frame.
//
// Ports
//   clk, reset_n        single clock, asynchronous active-low reset
//   address             host word address into the back bank
//   chipselect          host access qualifier
//   write / read        host strobes (write has priority over read)
//   byteenable          per-byte write enables
//   writedata           host write data
//   readdata            host read data, one cycle after the read
//   readdatavalid       single-cycle pulse marking readdata valid
//   swap_req            request a bank swap (pulse)
//   swap_pending        swap requested but not yet applied
//   swap_done           pulse in the cycle front_sel changes
//   front_sel           bank currently being scanned
//   frame_start         start a frame scan (pulse)
//   scan_busy           scan in progress
//   pix_data/valid/last scan output stream, held while stalled
//   pix_ready           downstream accepts the word
//   overrun             sticky: frame_start seen while a scan was running
//   clr_overrun         clears overrun (a same-cycle new overrun wins)
// ---------------------------------------------------------------------------
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | no scan; pending swaps are applied here
// S_SCAN | issuing front-bank reads 0..FRAME_WORDS-1 into the output buffer
// S_LAST | final word is on pix_data; waiting for it to be accepted
//
module framebuf_pingpong #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 13,
   parameter int FRAME_WORDS = 8192
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     address,
   input  logic                  chipselect,
   input  logic                  write,
   input  logic                  read,
   input  logic [DATA_W/8-1:0]   byteenable,
   input  logic [DATA_W-1:0]     writedata,
   output logic [DATA_W-1:0]     readdata,
   output logic                  readdatavalid,
   input  logic                  swap_req,
   output logic                  swap_pending,
   output logic                  swap_done,
   output logic                  front_sel,
   input  logic                  frame_start,
   output logic                  scan_busy,
   output logic [DATA_W-1:0]     pix_data,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  pix_last,
   output logic                  overrun,
   input  logic                  clr_overrun
);

   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(FRAME_WORDS);
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_LAST = 2'd2
   } state_t;

   // storage
   logic [DATA_W-1:0] bank0_mem [DEPTH];
   logic [DATA_W-1:0] bank1_mem [DEPTH];

   // registered state
   state_t            state_q,         state_d;
   logic [CNT_W-1:0]  cnt_q,           cnt_d;
   logic [DATA_W-1:0] out_data_q,      out_data_d;
   logic              out_valid_q,     out_valid_d;
   logic              out_last_q,      out_last_d;
   logic [DATA_W-1:0] skid_data_q,     skid_data_d;
   logic              skid_valid_q,    skid_valid_d;
   logic              skid_last_q,     skid_last_d;
   logic [DATA_W-1:0] readdata_q,      readdata_d;
   logic              readdatavalid_q, readdatavalid_d;
   logic              front_sel_q,     front_sel_d;
   logic              swap_pending_q,  swap_pending_d;
   logic              swap_done_q,     swap_done_d;
   logic              scan_busy_q,     scan_busy_d;
   logic              overrun_q,       overrun_d;

   // combinational helpers
   logic              host_wr;
   logic              host_rd;
   logic              pop;
   logic              issue;
   logic              issue_last;
   logic              swap_apply;
   logic [ADDR_W-1:0] scan_addr;
   logic [DATA_W-1:0] host_rd_word;
   logic [DATA_W-1:0] scan_word;

   assign scan_addr    = cnt_q[ADDR_W-1:0];
   // back bank is the one not being scanned
   assign host_rd_word = front_sel_q ? bank0_mem[address]   : bank1_mem[address];
   assign scan_word    = front_sel_q ? bank1_mem[scan_addr] : bank0_mem[scan_addr];

   // Host writes land in the back bank on the same edge; RAM is not reset.
   always_ff @(posedge clk) begin
      if (host_wr) begin
         for (int b = 0; b < BE_W; b++) begin
            if (byteenable[b]) begin
               if (front_sel_q) begin
                  bank0_mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
               end else begin
                  bank1_mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      host_wr         = chipselect & write;
      host_rd         = chipselect & read & ~write;
      readdata_d      = host_rd ? host_rd_word : readdata_q;
      readdatavalid_d = host_rd;

      // Output buffer: out_* drives the pins, skid_* holds the word whose
      // read was already issued when the head stalled. A read is issued
      // only if the buffer will have room for it after this edge, so the
      // stream never drops or repeats a word and has no bubbles.
      pop        = out_valid_q & pix_ready;
      issue      = (state_q == S_SCAN) && (cnt_q < FRAME_LEN) && (!skid_valid_q || pop);
      issue_last = (cnt_q == LAST_IDX);

      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      skid_last_d  = skid_last_q;

      if (!out_valid_q || pop) begin
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            out_last_d   = skid_last_q;
            skid_valid_d = issue;
            if (issue) begin
               skid_data_d = scan_word;
               skid_last_d = issue_last;
            end
         end else begin
            out_valid_d = issue;
            out_last_d  = issue & issue_last;
            if (issue) begin
               out_data_d = scan_word;
            end
         end
      end else if (issue) begin
         skid_data_d  = scan_word;
         skid_valid_d = 1'b1;
         skid_last_d  = issue_last;
      end

      cnt_d   = issue ? cnt_q + CNT_W'(1) : cnt_q;
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d = S_SCAN;
               cnt_d   = '0;
            end
         end
         S_SCAN: begin
            if (out_valid_d && out_last_d) begin
               state_d = S_LAST;
            end
         end
         S_LAST: begin
            if (pop) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      scan_busy_d = (state_d != S_IDLE);

      overrun_d = (frame_start & (state_q != S_IDLE)) | (overrun_q & ~clr_overrun);

      // A swap that was already pending when the scan ended is applied in
      // the first idle cycle even if a new frame starts on the same edge;
      // that scan then reads the new front bank. A fresh request that
      // coincides with frame_start waits for the end of that frame.
      swap_apply     = (state_q == S_IDLE) & (swap_pending_q | (swap_req & ~frame_start));
      front_sel_d    = front_sel_q ^ swap_apply;
      swap_pending_d = swap_apply ? 1'b0 : (swap_pending_q | swap_req);
      swap_done_d    = swap_apply;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         out_data_q      <= '0;
         out_valid_q     <= 1'b0;
         out_last_q      <= 1'b0;
         skid_data_q     <= '0;
         skid_valid_q    <= 1'b0;
         skid_last_q     <= 1'b0;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         front_sel_q     <= 1'b0;
         swap_pending_q  <= 1'b0;
         swap_done_q     <= 1'b0;
         scan_busy_q     <= 1'b0;
         overrun_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         out_data_q      <= out_data_d;
         out_valid_q     <= out_valid_d;
         out_last_q      <= out_last_d;
         skid_data_q     <= skid_data_d;
         skid_valid_q    <= skid_valid_d;
         skid_last_q     <= skid_last_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= readdatavalid_d;
         front_sel_q     <= front_sel_d;
         swap_pending_q  <= swap_pending_d;
         swap_done_q     <= swap_done_d;
         scan_busy_q     <= scan_busy_d;
         overrun_q       <= overrun_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = readdatavalid_q;
   assign swap_pending  = swap_pending_q;
   assign swap_done     = swap_done_q;
   assign front_sel     = front_sel_q;
   assign scan_busy     = scan_busy_q;
   assign pix_data      = out_data_q;
   assign pix_valid     = out_valid_q;
   assign pix_last      = out_last_q;
   assign overrun       = overrun_q;

endmodule
